// File: rtl/typed_nibble_deframer.sv
// typed_nibble_deframer
//   Receive side of the typed nibble link. Nibbles arrive framed as
//   SYNC, HI, LO and are reassembled into a byte. A frame that stalls for
//   TIMEOUT cycles is abandoned with a frame_err pulse. Good bytes are
//   counted modulo 256.
//
//   Type scoping:
//     - nibble_t and deframer_state_e live at compilation-unit scope.
//     - byte_t is declared at module scope.
//     - the g_assemble generate block declares its own byte_t, which
//       shadows the module-scope one inside that block.
//
//   Optional feature macro: TYPED_NIBBLE_PARITY_EN
//     When defined, every HI and LO nibble must have even parity over
//     {nib_data, nib_par}. A failing nibble aborts the frame with a
//     frame_err pulse. The SYNC nibble is never parity checked.
//     When undefined, nib_par is ignored and no parity logic exists.

typedef logic [3:0] nibble_t;

typedef enum logic [1:0] {
  ST_IDLE = 2'd0,
  ST_HI   = 2'd1,
  ST_LO   = 2'd2
} deframer_state_e;

module typed_nibble_deframer #(
  parameter logic [3:0]  SYNC    = 4'hA,
  parameter int unsigned TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       nib_valid,
  input  logic [3:0] nib_data,
  input  logic       nib_par,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err,
  output logic [7:0] byte_cnt
);

  typedef logic [7:0] byte_t;

  // The idle timer is 8 bits wide; TIMEOUT is legal over 1..255.
  localparam logic [7:0] TIMEOUT_L = 8'(TIMEOUT);

  deframer_state_e state_q, state_d;
  nibble_t         hi_q, hi_d;
  logic [7:0]      timer_q, timer_d;
  logic            byte_valid_q, byte_valid_d;
  byte_t           byte_data_q, byte_data_d;
  logic            frame_err_q, frame_err_d;
  logic [7:0]      byte_cnt_q, byte_cnt_d;

  nibble_t         nib;
  byte_t           assembled_byte;
  logic            par_bad;
  logic [7:0]      timer_inc;

  assign nib = nib_data;

  // Byte assembly uses a block-local byte_t that shadows the module one.
  if (1'b1) begin : g_assemble
    typedef logic [7:0] byte_t;
    byte_t local_byte;
    assign local_byte     = {hi_q, nib};
    assign assembled_byte = local_byte;
  end

`ifdef TYPED_NIBBLE_PARITY_EN
  // Even parity: XOR over the payload and its parity bit must be zero.
  assign par_bad = ^{nib_data, nib_par};
`else
  // Parity bit is accepted on the port but has no effect.
  logic unused_nib_par;
  assign unused_nib_par = nib_par;
  assign par_bad        = 1'b0;
`endif

  // Idle-cycle timer increment, saturating at TIMEOUT.
  assign timer_inc = (timer_q >= TIMEOUT_L) ? TIMEOUT_L : timer_q + 8'd1;

  // Next-state and registered-output logic for the frame FSM.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_d      = state_q;
    hi_d         = hi_q;
    timer_d      = timer_q;
    byte_valid_d = 1'b0;
    byte_data_d  = byte_data_q;
    frame_err_d  = 1'b0;
    byte_cnt_d   = byte_cnt_q;

    case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        // Non-SYNC nibbles are dropped without complaint.
        if (nib_valid && (nib == SYNC)) begin
          state_d = ST_HI;
        end
      end

      ST_HI, ST_LO: begin
        if (nib_valid) begin
          // An accepted nibble always restarts the idle timer, even on
          // the cycle the timer would otherwise have expired.
          timer_d = '0;
          if (par_bad) begin
            state_d     = ST_IDLE;
            frame_err_d = 1'b1;
          end else if (state_q == ST_HI) begin
            // A SYNC value here is plain data; there is no resync.
            hi_d    = nib;
            state_d = ST_LO;
          end else begin
            state_d      = ST_IDLE;
            byte_valid_d = 1'b1;
            byte_data_d  = assembled_byte;
            byte_cnt_d   = byte_cnt_q + 8'd1;
          end
        end else begin
          timer_d = timer_inc;
          if (timer_inc == TIMEOUT_L) begin
            state_d     = ST_IDLE;
            frame_err_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase
  end

  // State and output registers; reset discards any partial frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      hi_q         <= '0;
      timer_q      <= '0;
      byte_valid_q <= 1'b0;
      byte_data_q  <= '0;
      frame_err_q  <= 1'b0;
      byte_cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      hi_q         <= hi_d;
      timer_q      <= timer_d;
      byte_valid_q <= byte_valid_d;
      byte_data_q  <= byte_data_d;
      frame_err_q  <= frame_err_d;
      byte_cnt_q   <= byte_cnt_d;
    end
  end

  assign byte_valid = byte_valid_q;
  assign byte_data  = byte_data_q;
  assign frame_err  = frame_err_q;
  assign byte_cnt   = byte_cnt_q;

endmodule

// File: tb/tb_typed_nibble_deframer.sv
// tb_typed_nibble_deframer
//   Directed and randomized stimulus for typed_nibble_deframer, checked every
//   cycle against a frame-level behavioural model, plus literal expectations
//   for the documented scenarios. Honours TYPED_NIBBLE_PARITY_EN.

module tb_typed_nibble_deframer;

  localparam logic [3:0] SYNC    = 4'hA;
  localparam int         TIMEOUT = 8;

`ifdef TYPED_NIBBLE_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       nib_valid;
  logic [3:0] nib_data;
  logic       nib_par;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       frame_err;
  logic [7:0] byte_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  typed_nibble_deframer #(.SYNC(SYNC), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .nib_valid  (nib_valid),
    .nib_data   (nib_data),
    .nib_par    (nib_par),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_err  (frame_err),
    .byte_cnt   (byte_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_need: how many frame nibbles are still owed after SYNC (0 = hunting).
  int         m_need;
  logic [3:0] m_hi;
  int         m_idle;
  logic       exp_bv;
  logic [7:0] exp_bd;
  logic       exp_err;
  int         exp_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_need  = 0;
      m_hi    = '0;
      m_idle  = 0;
      exp_bv  = 1'b0;
      exp_bd  = '0;
      exp_err = 1'b0;
      exp_cnt = 0;
    end else begin
      exp_bv  = 1'b0;
      exp_err = 1'b0;
      if (m_need == 0) begin
        if (nib_valid && nib_data == SYNC) begin
          m_need = 2;
          m_idle = 0;
        end
      end else if (nib_valid) begin
        m_idle = 0;
        if (PAR_EN && ((^nib_data) != nib_par)) begin
          m_need  = 0;
          exp_err = 1'b1;
        end else if (m_need == 2) begin
          m_hi   = nib_data;
          m_need = 1;
        end else begin
          m_need  = 0;
          exp_bv  = 1'b1;
          exp_bd  = {m_hi, nib_data};
          exp_cnt = (exp_cnt + 1) % 256;
        end
      end else begin
        m_idle++;
        if (m_idle >= TIMEOUT) begin
          m_need  = 0;
          exp_err = 1'b1;
        end
      end
    end
  end

  // Per-cycle compare, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("byte_valid", byte_valid, exp_bv);
      check("byte_data", byte_data, exp_bd);
      check("frame_err", frame_err, exp_err);
      check("byte_cnt", byte_cnt, exp_cnt[7:0]);
      check("valid_err_exclusive", byte_valid & frame_err, 1'b0);
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic gp(input logic [3:0] d);
    return ^d;
  endfunction

  task automatic drive(input logic v, input logic [3:0] d, input logic p);
    @(negedge clk);
    nib_valid = v;
    nib_data  = d;
    nib_par   = p;
  endtask

  task automatic idle();
    drive(1'b0, 4'h0, 1'b0);
  endtask

  task automatic frame(input logic [3:0] hi, input logic [3:0] lo);
    drive(1'b1, SYNC, gp(SYNC));
    drive(1'b1, hi, gp(hi));
    drive(1'b1, lo, gp(lo));
  endtask

  // Asserts reset away from both clock edges and checks the reset values.
  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    nib_valid = 1'b0;
    nib_data  = 4'h0;
    nib_par   = 1'b0;
    #1;
    check("rst_byte_valid", byte_valid, 1'b0);
    check("rst_byte_data", byte_data, 8'h00);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_byte_cnt", byte_cnt, 8'h00);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int         r;
    logic [3:0] d;
    logic       p;

    rst_n     = 1'b0;
    nib_valid = 1'b0;
    nib_data  = 4'h0;
    nib_par   = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    cmp_en = 1'b1;

    // 1. Back-to-back frame, one-cycle latency.
    frame(4'h5, 4'hA);
    idle();
    check("t1_byte_valid", byte_valid, 1'b1);
    check("t1_byte_data", byte_data, 8'h5A);
    check("t1_byte_cnt", byte_cnt, 8'd1);

    // 2. Junk in IDLE is dropped silently.
    drive(1'b1, 4'h3, gp(4'h3));
    drive(1'b1, 4'h7, gp(4'h7));
    frame(4'h4, 4'h2);
    idle();
    check("t2_byte_data", byte_data, 8'h42);
    check("t2_byte_cnt", byte_cnt, 8'd2);
    check("t2_frame_err", frame_err, 1'b0);

    // 3. Timeout after TIMEOUT idle cycles mid-frame, then recovery.
    drive(1'b1, SYNC, gp(SYNC));
    drive(1'b1, 4'h4, gp(4'h4));
    repeat (TIMEOUT) idle();
    idle();
    check("t3_frame_err", frame_err, 1'b1);
    check("t3_no_byte", byte_valid, 1'b0);
    frame(4'h1, 4'h2);
    idle();
    check("t3_byte_data", byte_data, 8'h12);
    check("t3_byte_cnt", byte_cnt, 8'd3);

    // Boundary: a nibble arriving on the expiry cycle is accepted.
    drive(1'b1, SYNC, gp(SYNC));
    drive(1'b1, 4'h6, gp(4'h6));
    repeat (TIMEOUT - 1) idle();
    drive(1'b1, 4'h9, gp(4'h9));
    idle();
    check("edge_byte_valid", byte_valid, 1'b1);
    check("edge_byte_data", byte_data, 8'h69);
    check("edge_frame_err", frame_err, 1'b0);

    // SYNC value inside a frame is data; back-to-back frames with no bubble.
    frame(SYNC, SYNC);
    frame(4'hC, 4'h3);
    idle();
    check("b2b_byte_data", byte_data, 8'hC3);
    check("b2b_byte_cnt", byte_cnt, 8'd6);

    // 5. Parity scenario.
    drive(1'b1, SYNC, 1'b0);
    drive(1'b1, 4'h3, 1'b1);
    drive(1'b1, 4'h5, 1'b0);
    check("t5_bad_frame_err", frame_err, PAR_EN ? 1'b1 : 1'b0);
    idle();
    check("t5_bad_byte_valid", byte_valid, PAR_EN ? 1'b0 : 1'b1);
    drive(1'b1, SYNC, 1'b1);
    drive(1'b1, 4'h3, 1'b0);
    drive(1'b1, 4'h5, 1'b0);
    idle();
    check("t5_good_byte_valid", byte_valid, 1'b1);
    check("t5_good_byte_data", byte_data, 8'h35);

    // Randomized traffic: junk, SYNC-heavy data, bad parity, long stalls.
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 19);
      if (r == 0) begin
        repeat ($urandom_range(TIMEOUT - 2, TIMEOUT + 3)) idle();
      end else if (r < 5) begin
        idle();
      end else begin
        d = ($urandom_range(0, 2) == 0) ? SYNC : 4'($urandom);
        p = ($urandom_range(0, 9) == 0) ? ~gp(d) : gp(d);
        drive(1'b1, d, p);
      end
    end
    idle();

    // 4. Counter wrap over 256 good frames, then reset mid-frame.
    do_reset();
    for (int i = 0; i < 256; i++) begin
      frame(4'($urandom), 4'($urandom));
    end
    idle();
    check("t4_byte_cnt_wrap", byte_cnt, 8'd0);
    check("t4_last_valid", byte_valid, 1'b1);

    drive(1'b1, SYNC, gp(SYNC));
    drive(1'b1, 4'h7, gp(4'h7));
    do_reset();
    repeat (TIMEOUT + 2) begin
      idle();
      check("t4_no_err_after_reset", frame_err, 1'b0);
    end
    frame(4'hB, 4'hE);
    idle();
    check("t4_post_reset_data", byte_data, 8'hBE);
    check("t4_post_reset_cnt", byte_cnt, 8'd1);

    idle();
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
